// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux: N-digit hex seven-segment scanner with frame-latched shadow value; optional SSD_BRIGHTNESS_EN duty control.
// Outputs are registered one clk behind the scan index; free-running, no backpressure.
module ssd_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
`ifdef SSD_BRIGHTNESS_EN
  input  logic [3:0]              brightness,
`endif
  output logic [6:0]              anodes,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    slot_end;
  logic                    wrap;
  logic                    duty_on;

  logic [3:0]              nib;
  logic                    cur_dp;
  logic                    cur_en;
  logic [NUM_DIGITS-1:0]   sel_oh;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    blank;
  logic                    lit;

  function automatic logic [6:0] seg7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign slot_end   = (cnt == CNT_LAST);
  assign wrap       = slot_end && (idx == IDX_LAST);
  assign frame_done = wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      idx       <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      // Shadow only moves at the frame boundary so a frame never mixes two values.
      if (wrap) begin
        shadow    <= value;
        shadow_dp <= dp_in;
      end
    end
  end

`ifdef SSD_BRIGHTNESS_EN
  always_comb begin
    duty_on = int'(cnt) < (((int'(brightness) + 1) * REFRESH_DIV) / 16);
  end
`else
  assign duty_on = 1'b1;
`endif

  always_comb begin
    logic lz_run;
    nib     = 4'h0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    sel_oh  = '0;
    lz_mask = '0;
    lz_run  = 1'b1;
    // lz_mask[i] is set when nibbles from the top down to i are all zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run     = lz_run & (shadow[4*i +: 4] == 4'h0);
      lz_mask[i] = lz_run;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(idx) == i) begin
        nib       = shadow[4*i +: 4];
        cur_dp    = shadow_dp[i];
        cur_en    = digit_en[i];
        sel_oh[i] = 1'b1;
      end
    end
    blank = blank_lz && (idx != '0) && (|(lz_mask & sel_oh));
    lit   = cur_en && duty_on;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anodes    <= 7'h7F;
      dp_n      <= 1'b1;
      digit_sel <= '0;
    end else if (lit) begin
      digit_sel <= sel_oh;
      anodes    <= blank ? 7'h7F : seg7(nib);
      dp_n      <= ~cur_dp;
    end else begin
      digit_sel <= '0;
      anodes    <= 7'h7F;
      dp_n      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Bench for ssd_scan_mux: directed scan/tearing/blanking/enable/reset steps plus random traffic against a time-indexed model.
module tb_ssd_scan_mux;
  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        blank_lz;
`ifdef SSD_BRIGHTNESS_EN
  logic [3:0]  brightness;
`endif
  logic [6:0]  anodes;
  logic        dp_n;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int k;
  logic [15:0] sh_m;
  logic [3:0]  shdp_m;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  ssd_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .dp_in(dp_in),
    .digit_en(digit_en),
    .blank_lz(blank_lz),
`ifdef SSD_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .anodes(anodes),
    .dp_n(dp_n),
    .digit_sel(digit_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected registered outputs produced from the scan position k cycles after reset.
  task automatic model(input int kk, output logic [3:0] es, output logic [6:0] ea, output logic ed);
    int d;
    int tick;
    logic on;
    logic [15:0] upper;
    d    = (kk / RD) % ND;
    tick = kk % RD;
    on   = digit_en[d];
`ifdef SSD_BRIGHTNESS_EN
    if (tick >= ((int'(brightness) + 1) * RD) / 16) on = 1'b0;
`else
    if (tick < 0) on = 1'b0;
`endif
    if (!on) begin
      es = 4'b0;
      ea = 7'h7F;
      ed = 1'b1;
    end else begin
      es    = 4'(1 << d);
      upper = sh_m >> (4 * d);
      if (blank_lz && d > 0 && upper == 16'h0) ea = 7'h7F;
      else ea = seg_tab[upper[3:0]];
      ed = ~shdp_m[d];
    end
  endtask

  task automatic step();
    logic [3:0] es;
    logic [6:0] ea;
    logic       ed;
    chk($sformatf("frame_done k=%0d", k), 32'(frame_done), 32'(k % FRAME == FRAME - 1));
    model(k, es, ea, ed);
    if (k % FRAME == FRAME - 1) begin
      sh_m   = value;
      shdp_m = dp_in;
    end
    @(posedge clk);
    #1;
    k++;
    chk($sformatf("digit_sel k=%0d", k), 32'(digit_sel), 32'(es));
    chk($sformatf("anodes k=%0d", k), 32'(anodes), 32'(ea));
    chk($sformatf("dp_n k=%0d", k), 32'(dp_n), 32'(ed));
  endtask

  task automatic release_reset();
    reset  = 1'b1;
    k      = 0;
    sh_m   = 16'h0;
    shdp_m = 4'h0;
  endtask

  task automatic chk_off(input string tag);
    chk({tag, " anodes"}, 32'(anodes), 32'h7F);
    chk({tag, " dp_n"}, 32'(dp_n), 32'h1);
    chk({tag, " digit_sel"}, 32'(digit_sel), 32'h0);
    chk({tag, " frame_done"}, 32'(frame_done), 32'h0);
  endtask

  initial begin
    value    = 16'h1234;
    dp_in    = 4'h0;
    digit_en = 4'hF;
    blank_lz = 1'b0;
`ifdef SSD_BRIGHTNESS_EN
    brightness = 4'hF;
`endif
    k      = 0;
    sh_m   = 16'h0;
    shdp_m = 4'h0;

    #12;
    chk_off("reset_initial");
    @(posedge clk);
    #1;
    release_reset();

    // First frame shows 0; then 1234 scans.
    step();
    chk("first_digit_sel", 32'(digit_sel), 32'h1);
    chk("first_anodes", 32'(anodes), 32'h40);
    repeat (3 * FRAME) step();

    // Change value mid-frame; must not show until the next wrap.
    while ((k / RD) % ND != 1) step();
    value = 16'hABCD;
    repeat (2 * FRAME) step();

    blank_lz = 1'b1;
    value    = 16'h0042;
    repeat (2 * FRAME) step();
    value = 16'h0000;
    repeat (2 * FRAME) step();

    blank_lz = 1'b0;
    value    = 16'h1234;
    digit_en = 4'b1010;
    dp_in    = 4'b0010;
    repeat (2 * FRAME) step();

    digit_en = 4'b0000;
    repeat (2 * FRAME) step();

    // Reset in the middle of a slot.
    digit_en = 4'hF;
    repeat (6) step();
    #2;
    reset = 1'b0;
    #1;
    chk_off("reset_mid");
    @(posedge clk);
    #1;
    chk_off("reset_held");
    release_reset();
    step();
    chk("restart_digit_sel", 32'(digit_sel), 32'h1);
    chk("restart_anodes", 32'(anodes), 32'h40);
    repeat (FRAME) step();

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) value = 16'($urandom);
      if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 15) == 0) value = {8'h00, 8'($urandom_range(0, 3))};
`ifdef SSD_BRIGHTNESS_EN
      if ($urandom_range(0, 15) == 0) brightness = 4'($urandom);
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
